multi_cycle_cu: RTL and testbench
=================================

# multi_cycle_cu

Main control FSM for the multi-cycle MIPS core. It replaces the single-cycle combinational `mcu` when the instruction and data memories are merged into one shared memory port, and the ALU also computes PC+4 and the branch target. The block sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath mux selects and write enables, and stalls on a memory-ready handshake.

## Interface
Parameters:
- none; the state encoding is fixed (below).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; forces FETCH, clears counter
- `opcode`  in  6  instr[31:26] from the instruction register
- `mem_ready`  in  1  shared memory has completed the current read/write this cycle
- `pc_we`  out  1  unconditional PC write
- `branch`  out  1  PC write if ALU `eq`; datapath forms `pc_we | (branch & eq)`
- `iord`  out  1  memory address select: 0 = PC, 1 = ALU result register
- `mem_rd`  out  1  memory read request
- `mem_we`  out  1  memory write request
- `ir_we`  out  1  instruction register load
- `reg_we`  out  1  register file write
- `wreg_dst_sel`  out  1  1 = rd (instr[15:11]), 0 = rt (instr[20:16])
- `wrbck_sel`  out  1  1 = memory data register, 0 = ALU result register
- `alu_src_a`  out  1  0 = PC, 1 = rs register value
- `alu_src_b`  out  2  00 = rt value, 01 = constant 4, 10 = sign_imm, 11 = sign_imm<<2
- `aluop`  out  2  to `alu_cu`: 00 = add, 01 = sub, 10 = decode funct
- `pc_src`  out  2  00 = ALU result, 01 = ALU-out register (branch target), 10 = jump target
- `illegal_op`  out  1  one-cycle flag: unsupported opcode decoded
- `state_debug`  out  4  current state encoding
- `instr_count`  out  32  retired-instruction counter

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Codes 12–15 are unreachable and map to FETCH on the next edge.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Outputs are a function of the state only, except the write enables gated by `mem_ready` (noted below). Every output not listed for a state is 0.
- FETCH: `mem_rd`=1, `alu_src_b`=01, `ir_we`=`pc_we`=`mem_ready`. Stay in FETCH while `mem_ready`=0, else go to DECODE.
- DECODE: `alu_src_b`=11 (branch target precomputed). Next state by opcode: lw/sw→MEMADR, R→EXECUTE, beq→BRANCH, addi→ADDIEXEC, j→JUMP. Any other opcode: `illegal_op`=1, next state FETCH.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: `iord`=1, `mem_rd`=1. Hold until `mem_ready`, then go to MEMWB.
- MEMWB: `reg_we`=1, `wrbck_sel`=1, `wreg_dst_sel`=0. Next state FETCH.
- MEMWR: `iord`=1, `mem_we`=1, held every cycle while waiting. On `mem_ready`, go to FETCH.
- EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `aluop`=10. Next state ALUWB.
- ALUWB: `reg_we`=1, `wreg_dst_sel`=1. Next state FETCH.
- BRANCH: `alu_src_a`=1, `aluop`=01, `branch`=1, `pc_src`=01. Next state FETCH.
- ADDIEXEC: `alu_src_a`=1, `alu_src_b`=10. Next state ADDIWB.
- ADDIWB: `reg_we`=1, `wreg_dst_sel`=0. Next state FETCH.
- JUMP: `pc_we`=1, `pc_src`=10. Next state FETCH.
- `instr_count` increments by 1 (mod 2^32) on each edge that leaves MEMWB, ALUWB, BRANCH, ADDIWB or JUMP, or leaves MEMWR with `mem_ready`=1. Illegal opcodes are not counted.

## Timing
- Reset asserted: state=FETCH and `instr_count`=0, both immediately (asynchronous). `pc_we`, `ir_we`, `reg_we`, `mem_we`, `branch` and `illegal_op` are forced to 0 while `reset`=1. Other outputs take their FETCH values.
- First FETCH transfer happens on the first rising edge after reset deassertion with `mem_ready`=1.
- Cycle counts with `mem_ready` held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- `opcode` is sampled only in DECODE and MEMADR. The IR is stable there because `ir_we` is asserted only in FETCH.
- Reset mid-instruction abandons the instruction without a write. No state survives except the external PC and register file.

## Test plan
- Reset with `mem_ready`=1 → `state_debug`=0, `instr_count`=0, all write enables 0. Release reset; after one edge `state_debug`=1.
- lw (100011), `mem_ready`=1 → states 0,1,2,3,4,0. `reg_we`=1 and `wrbck_sel`=1 only in state 4. `instr_count` becomes 1 after 5 edges.
- sw with `mem_ready` low for 3 cycles in MEMWR → `mem_we`=1 and `iord`=1 for 4 consecutive cycles, then FETCH. The instruction takes 7 cycles total.
- beq then j back-to-back → BRANCH shows `branch`=1, `aluop`=01, `pc_src`=01; JUMP shows `pc_we`=1, `pc_src`=10. `instr_count`=2 after 6 edges.
- Opcode 111111 → `illegal_op`=1 for exactly the DECODE cycle, then FETCH. `instr_count` is unchanged.
- Assert `reset` asynchronously in MEMRD → `state_debug`=0 and `instr_count`=0 before the next clock edge, with no `reg_we` pulse.

Source files
------------

// File: rtl/multi_cycle_cu.sv
`default_nettype none
// ============================================================================
//  Module   : multi_cycle_cu
//  Purpose  : Main control FSM of the multi-cycle MIPS core. Sequences each
//             instruction through fetch / decode / execute / memory /
//             writeback, drives the datapath selects and write enables, and
//             stalls on the shared-memory ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_cycle_cu (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        branch,
  output logic        iord,
  output logic        mem_rd,
  output logic        mem_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic        wreg_dst_sel,
  output logic        wrbck_sel,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  aluop,
  output logic [1:0]  pc_src,
  output logic        illegal_op,
  output logic [3:0]  state_debug,
  output logic [31:0] instr_count
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMRD    = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWR    = 4'd5;
  localparam logic [3:0] EXECUTE  = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] ADDIEXEC = 4'd9;
  localparam logic [3:0] ADDIWB   = 4'd10;
  localparam logic [3:0] JUMP     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] state;
  logic [3:0] next_state;
  logic       retire;

  // Ungated write strobes; reset masks them before they reach the ports.
  logic pc_we_s, branch_s, mem_we_s, ir_we_s, reg_we_s, illegal_s;

  // Next-state selection and detection of the edge that retires an instruction
  always_comb begin
    next_state = FETCH;
    retire     = 1'b0;
    case (state)
      FETCH:    next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEXEC;
          OP_J:         next_state = JUMP;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    next_state = mem_ready ? MEMWB : MEMRD;
      MEMWB: begin
        next_state = FETCH;
        retire     = 1'b1;
      end
      MEMWR: begin
        next_state = mem_ready ? FETCH : MEMWR;
        retire     = mem_ready;
      end
      EXECUTE:  next_state = ALUWB;
      ALUWB, BRANCH, ADDIWB, JUMP: begin
        next_state = FETCH;
        retire     = 1'b1;
      end
      ADDIEXEC: next_state = ADDIWB;
      default:  next_state = FETCH;   // unused codes recover to FETCH
    endcase
  end

  // Per-state datapath controls; only the FETCH strobes depend on mem_ready
  always_comb begin
    pc_we_s      = 1'b0;
    branch_s     = 1'b0;
    iord         = 1'b0;
    mem_rd       = 1'b0;
    mem_we_s     = 1'b0;
    ir_we_s      = 1'b0;
    reg_we_s     = 1'b0;
    wreg_dst_sel = 1'b0;
    wrbck_sel    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    aluop        = 2'b00;
    pc_src       = 2'b00;
    illegal_s    = 1'b0;
    case (state)
      FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        ir_we_s   = mem_ready;
        pc_we_s   = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        illegal_s = !(opcode == OP_LW || opcode == OP_SW || opcode == OP_RTYPE ||
                      opcode == OP_BEQ || opcode == OP_ADDI || opcode == OP_J);
      end
      MEMADR, ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        iord   = 1'b1;
        mem_rd = 1'b1;
      end
      MEMWB: begin
        reg_we_s  = 1'b1;
        wrbck_sel = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        mem_we_s = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        aluop     = 2'b10;
      end
      ALUWB: begin
        reg_we_s     = 1'b1;
        wreg_dst_sel = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        aluop     = 2'b01;
        branch_s  = 1'b1;
        pc_src    = 2'b01;
      end
      ADDIWB:   reg_we_s = 1'b1;
      JUMP: begin
        pc_we_s = 1'b1;
        pc_src  = 2'b10;
      end
      default: ;
    endcase
  end

  // Write strobes are suppressed for as long as reset is held
  always_comb begin
    pc_we      = pc_we_s   & ~reset;
    branch     = branch_s  & ~reset;
    mem_we     = mem_we_s  & ~reset;
    ir_we      = ir_we_s   & ~reset;
    reg_we     = reg_we_s  & ~reset;
    illegal_op = illegal_s & ~reset;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       instr_count <= 32'd0;
    else if (retire) instr_count <= instr_count + 32'd1;
  end

  assign state_debug = state;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_cu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_cycle_cu
//  Purpose  : Scoreboard bench for multi_cycle_cu. A driver expands each
//             instruction into its expected per-cycle control word from the
//             state/opcode table and queues it; a monitor checks the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_cu;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_we, branch, iord, mem_rd, mem_we, ir_we, reg_we;
    logic       wreg_dst_sel, wrbck_sel, alu_src_a;
    logic [1:0] alu_src_b, aluop, pc_src;
    logic       illegal_op;
  } ctl_t;

  typedef struct packed {
    ctl_t        c;
    logic [31:0] cnt;
  } item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_we, branch, iord, mem_rd, mem_we, ir_we, reg_we;
  logic        wreg_dst_sel, wrbck_sel, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, aluop, pc_src;
  logic [3:0]  state_debug;
  logic [31:0] instr_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_cnt = 32'd0;
  item_t       sb[$];

  multi_cycle_cu dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_we(pc_we), .branch(branch), .iord(iord), .mem_rd(mem_rd),
    .mem_we(mem_we), .ir_we(ir_we), .reg_we(reg_we),
    .wreg_dst_sel(wreg_dst_sel), .wrbck_sel(wrbck_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
    .pc_src(pc_src), .illegal_op(illegal_op), .state_debug(state_debug),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic is_legal(input logic [5:0] op);
    return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
           op == OP_ADDI || op == OP_J;
  endfunction

  // Reference control word for one cycle spent in phase ph
  function automatic ctl_t ctl(input logic [3:0] ph, input logic [5:0] op, input logic mr);
    ctl_t c;
    c = '0;
    c.st = ph;
    case (ph)
      4'd0:  begin c.mem_rd = 1; c.alu_src_b = 2'b01; c.ir_we = mr; c.pc_we = mr; end
      4'd1:  begin c.alu_src_b = 2'b11; c.illegal_op = !is_legal(op); end
      4'd2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4'd3:  begin c.iord = 1; c.mem_rd = 1; end
      4'd4:  begin c.reg_we = 1; c.wrbck_sel = 1; end
      4'd5:  begin c.iord = 1; c.mem_we = 1; end
      4'd6:  begin c.alu_src_a = 1; c.aluop = 2'b10; end
      4'd7:  begin c.reg_we = 1; c.wreg_dst_sel = 1; end
      4'd8:  begin c.alu_src_a = 1; c.aluop = 2'b01; c.branch = 1; c.pc_src = 2'b01; end
      4'd9:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4'd10: c.reg_we = 1;
      4'd11: begin c.pc_we = 1; c.pc_src = 2'b10; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Apply one cycle of stimulus and queue what the DUT must show in it
  task automatic step(input logic [3:0] ph, input logic [5:0] op, input logic mr);
    item_t it;
    opcode    = op;
    mem_ready = mr;
    it.c   = ctl(ph, op, mr);
    it.cnt = model_cnt;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // One whole instruction: fw stall cycles in fetch, mw in the memory phase
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) step(4'd0, 6'($urandom), 1'b0);
    step(4'd0, 6'($urandom), 1'b1);
    step(4'd1, op, rb());
    case (op)
      OP_LW: begin
        step(4'd2, op, rb());
        for (int i = 0; i < mw; i++) step(4'd3, op, 1'b0);
        step(4'd3, op, 1'b1);
        step(4'd4, op, rb());
        model_cnt++;
      end
      OP_SW: begin
        step(4'd2, op, rb());
        for (int i = 0; i < mw; i++) step(4'd5, op, 1'b0);
        step(4'd5, op, 1'b1);
        model_cnt++;
      end
      OP_R:    begin step(4'd6, op, rb()); step(4'd7, op, rb());  model_cnt++; end
      OP_BEQ:  begin step(4'd8, op, rb()); model_cnt++; end
      OP_ADDI: begin step(4'd9, op, rb()); step(4'd10, op, rb()); model_cnt++; end
      OP_J:    begin step(4'd11, op, rb()); model_cnt++; end
      default: ;
    endcase
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp_v);
    end
  endtask

  // Monitor: one queued expectation per cycle, checked mid-cycle
  always begin
    item_t e;
    ctl_t  a;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '{state_debug, pc_we, branch, iord, mem_rd, mem_we, ir_we, reg_we,
            wreg_dst_sel, wrbck_sel, alu_src_a, alu_src_b, aluop, pc_src, illegal_op};
      check("ctl", 64'(a), 64'(e.c));
      check("instr_count", 64'(instr_count), 64'(e.cnt));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] op;
    int         r;
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = OP_LW;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 64'(state_debug), 64'd0);
    check("reset_count", 64'(instr_count), 64'd0);
    check("reset_we", 64'({pc_we, ir_we, reg_we, mem_we, branch, illegal_op}), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed scenarios
    run_instr(OP_LW, 0, 0);
    run_instr(OP_SW, 0, 3);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(OP_R, 2, 0);
    run_instr(OP_ADDI, 1, 0);
    run_instr(OP_LW, 1, 2);

    // Random instruction stream
    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1:    op = OP_LW;
        2, 3:    op = OP_SW;
        4, 9:    op = OP_R;
        5:       op = OP_BEQ;
        6:       op = OP_ADDI;
        7:       op = OP_J;
        default: begin
          op = 6'($urandom);
          while (is_legal(op)) op = 6'($urandom);
        end
      endcase
      run_instr(op, rb() ? 0 : int'($urandom_range(1, 3)),
                    rb() ? 0 : int'($urandom_range(1, 3)));
    end

    // Drain the scoreboard, bounded
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset while a load waits in MEMRD
    step(4'd0, OP_LW, 1'b1);
    step(4'd1, OP_LW, 1'b1);
    step(4'd2, OP_LW, 1'b1);
    mem_ready = 1'b0;
    #1;
    check("pre_reset_memrd", 64'(state_debug), 64'd3);
    check("pre_reset_count_nonzero", 64'(instr_count != 32'd0), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_state", 64'(state_debug), 64'd0);
    check("async_reset_count", 64'(instr_count), 64'd0);
    check("async_reset_reg_we", 64'(reg_we), 64'd0);
    mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("held_reset_we", 64'({pc_we, ir_we, reg_we, mem_we, branch, illegal_op}), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
